// File: rtl/pancake_pkg.sv
// pancake_pkg: constants shared by the cursor, shop/menu and display blocks.
package pancake_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;
  localparam int KEY_CLICK = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 4;
  localparam int KEY_N     = 5;
  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 3;
endpackage

// File: rtl/key_edge_det.sv
// key_edge_det: registered rising-edge detector; history resets high so keys held at reset never fire.
module key_edge_det #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);
  logic [N-1:0] in_q, in_q2, rise_q, rise_d;
  always_comb rise_d = in_q & ~in_q2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q   <= '1;
      in_q2  <= '1;
      rise_q <= '0;
    end else begin
      in_q   <= din;
      in_q2  <= in_q;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: key edges -> arbitrated, locked-out cursor moves and Enter strobes on a COLS x ROWS grid.
// Define CURSOR_WRAP_EN to wrap at grid edges; otherwise moves clamp.
module cursor_ctrl
  import pancake_pkg::*;
#(
  parameter int COLS    = GRID_COLS,
  parameter int ROWS    = GRID_ROWS,
  parameter int LOCKOUT = 50000,
  parameter int CNT_W   = 16,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int IW = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          click,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          sel_pulse,
  output logic [IW-1:0] sel_idx,
  output logic          moved,
  output logic          busy
);
  localparam logic [XW-1:0]    X_MAX   = XW'(COLS-1);
  localparam logic [YW-1:0]    Y_MAX   = YW'(ROWS-1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'((LOCKOUT == 0) ? 0 : LOCKOUT-1);
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [KEY_N-1:0] rise;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XW-1:0]    cur_x_q, cur_x_d;
  logic [YW-1:0]    cur_y_q, cur_y_d;
  logic [IW-1:0]    sel_idx_q, sel_idx_d;
  logic             sel_pulse_q, sel_pulse_d, moved_q, moved_d;
  key_edge_det #(.N(KEY_N)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({right, left, down, up, click}),
    .rise (rise)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    sel_idx_d   = sel_idx_q;
    sel_pulse_d = 1'b0;
    if (state_q == ST_LOCK) begin
      cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      state_d = (cnt_q == '0) ? ST_IDLE : ST_LOCK;
    end else if (|rise) begin
      state_d = (LOCKOUT == 0) ? ST_IDLE : ST_LOCK;
      cnt_d   = LOCK_LD;
      // Priority click > up > down > left > right; losers are dropped
      if (rise[KEY_CLICK]) begin
        sel_pulse_d = 1'b1;
        sel_idx_d   = IW'(cur_y_q) * IW'(COLS) + IW'(cur_x_q);
      end else if (rise[KEY_UP])
        cur_y_d = (cur_y_q == '0) ? (WRAP ? Y_MAX : cur_y_q) : cur_y_q - 1'b1;
      else if (rise[KEY_DOWN])
        cur_y_d = (cur_y_q == Y_MAX) ? (WRAP ? '0 : cur_y_q) : cur_y_q + 1'b1;
      else if (rise[KEY_LEFT])
        cur_x_d = (cur_x_q == '0) ? (WRAP ? X_MAX : cur_x_q) : cur_x_q - 1'b1;
      else
        cur_x_d = (cur_x_q == X_MAX) ? (WRAP ? '0 : cur_x_q) : cur_x_q + 1'b1;
    end
    moved_d = (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      sel_idx_q   <= '0;
      sel_pulse_q <= 1'b0;
      moved_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      sel_idx_q   <= sel_idx_d;
      sel_pulse_q <= sel_pulse_d;
      moved_q     <= moved_d;
    end
  end
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign sel_idx   = sel_idx_q;
  assign sel_pulse = sel_pulse_q;
  assign moved     = moved_q;
  assign busy      = (state_q == ST_LOCK);
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: scoreboard bench; expected events queued by stimulus, popped when the DUT strobes.
module tb_cursor_ctrl;
  localparam int LOCKOUT = 8;
  typedef struct {
    bit sel;
    bit mv;
    int x;
    int y;
    int idx;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       click = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [1:0] cur_x, cur_y;
  logic [3:0] sel_idx;
  logic       sel_pulse, moved, busy;
  int         checks = 0, failures = 0, sel_cnt = 0;
  ev_t        exp_q[$];
  cursor_ctrl #(.COLS(4), .ROWS(3), .LOCKOUT(LOCKOUT), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .click     (click),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .sel_pulse (sel_pulse),
    .sel_idx   (sel_idx),
    .moved     (moved),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic push_ev(input bit s, input bit m, input int x, input int y);
    ev_t e;
    e.sel = s;
    e.mv  = m;
    e.x   = x;
    e.y   = y;
    e.idx = y * 4 + x;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rst && (sel_pulse || moved)) begin
      if (sel_pulse) sel_cnt++;
      if (exp_q.size() == 0) chk("unexpected_event", int'({sel_pulse, moved}), 0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_sel", int'(sel_pulse), int'(e.sel));
        chk("ev_moved", int'(moved), int'(e.mv));
        chk("ev_x", int'(cur_x), e.x);
        chk("ev_y", int'(cur_y), e.y);
        if (e.sel) chk("ev_sel_idx", int'(sel_idx), e.idx);
      end
    end
  end
  task automatic set_keys(input logic [4:0] k);
    {click, up, down, left, right} = k;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);
    chk("rst_sel_pulse", int'(sel_pulse), 0);
    chk("rst_sel_idx", int'(sel_idx), 0);
    chk("rst_moved", int'(moved), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask
  // Drives k for 2 cycles; returns at the negedge where the resulting outputs are visible
  task automatic press(input logic [4:0] k);
    @(posedge clk);
    #1 set_keys(k);
    repeat (2) @(posedge clk);
    #1 set_keys(5'b0);
    repeat (2) @(negedge clk);
  endtask
  task automatic settle();
    repeat (LOCKOUT + 4) @(posedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    do_reset();
    // 1: latency, single moved strobe, busy length
    push_ev(0, 1, 1, 0);
    @(posedge clk);
    #1 right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_latency_x", int'(cur_x), 0);
    end
    @(posedge clk);
    #1 right = 1'b0;
    @(negedge clk);
    chk("t1_cur_x", int'(cur_x), 1);
    chk("t1_moved", int'(moved), 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", n, LOCKOUT);
    settle();
    // 2: held click fires exactly once
    do_reset();
    n = sel_cnt;
    push_ev(1, 0, 0, 0);
    @(posedge clk);
    #1 click = 1'b1;
    repeat (200) @(posedge clk);
    #1 click = 1'b0;
    repeat (30) @(posedge clk);
    chk("t2_sel_count", sel_cnt - n, 1);
    chk("t2_pending", exp_q.size(), 0);
    // 3: up and click together -> click wins, up dropped
    push_ev(0, 1, 0, 1);
    press(5'b00100);
    settle();
    push_ev(1, 0, 0, 1);
    press(5'b11000);
    settle();
    chk("t3_cur_y", int'(cur_y), 1);
    chk("t3_pending", exp_q.size(), 0);
    // 4: right at x=3
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      push_ev(0, 1, i, 0);
      press(5'b00001);
      settle();
    end
`ifdef CURSOR_WRAP_EN
    push_ev(0, 1, 0, 0);
    press(5'b00001);
    chk("t4_cur_x", int'(cur_x), 0);
    chk("t4_moved", int'(moved), 1);
`else
    press(5'b00001);
    chk("t4_cur_x", int'(cur_x), 3);
    chk("t4_moved", int'(moved), 0);
`endif
    chk("t4_busy", int'(busy), 1);
    settle();
    // 5: press inside LOCK ignored, press after LOCK accepted
    do_reset();
    push_ev(0, 1, 1, 0);
    press(5'b00001);
    @(posedge clk);
    #1 left = 1'b1;
    repeat (2) @(posedge clk);
    #1 left = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t5_busy_fell", int'(busy), 0);
    repeat (6) @(posedge clk);
    chk("t5_ignored_x", int'(cur_x), 1);
    push_ev(0, 1, 0, 0);
    press(5'b00010);
    chk("t5_moved_x", int'(cur_x), 0);
    settle();
    // 6: reset mid-LOCK with left held through release
    do_reset();
    push_ev(0, 1, 1, 0);
    press(5'b00001);
    settle();
    push_ev(0, 1, 2, 0);
    press(5'b00001);
    settle();
    push_ev(0, 1, 2, 1);
    press(5'b00100);
    chk("t6_pre_x", int'(cur_x), 2);
    chk("t6_pre_y", int'(cur_y), 1);
    @(posedge clk);
    #1 left = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_x", int'(cur_x), 0);
    chk("t6_rst_y", int'(cur_y), 0);
    chk("t6_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1 left = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_post_x", int'(cur_x), 0);
    chk("t6_post_busy", int'(busy), 0);
    chk("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
